// File: rtl/memoria_principal.sv
// Main-memory responder: 16-byte block reads with programmable latency and
// posted 64-bit writes every cycle.
module memoria_principal #(
    parameter int unsigned ADDR_WORDS   = 256,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  mem_address,
    input  logic [63:0]  mem_write_data,
    input  logic         mem_read_out,
    input  logic         mem_write_out,
    output logic [127:0] mem_block_read_data,
    output logic         mem_ready,
    output logic         busy,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);
    localparam int unsigned AW = $clog2(ADDR_WORDS);
    localparam logic [3:0] LAT_LOAD = 4'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, COOL} state_t;

    state_t        state, state_next;
    logic [3:0]    lat_cnt, lat_cnt_next;
    logic [AW-1:0] blk_idx, blk_idx_next;
    logic [AW-1:0] odd_idx;
    logic [AW-1:0] word_idx;
    logic          enter_resp;
    logic          addr_unused;

    logic [63:0] mem [ADDR_WORDS] = '{default: '0};

    assign word_idx    = mem_address[3 +: AW];
    assign addr_unused = ^mem_address;
    assign busy        = (state != IDLE);

    always_comb begin
        odd_idx    = blk_idx_next;
        odd_idx[0] = 1'b1;
    end

    // blk_idx_next equals the latched index outside IDLE, so it also serves
    // the READ_LATENCY=1 case where the index is captured on the RESP edge.
    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        blk_idx_next = blk_idx;
        enter_resp   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_read_out && !mem_write_out) begin
                    blk_idx_next    = word_idx;
                    blk_idx_next[0] = 1'b0;
                    if (READ_LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        lat_cnt_next = LAT_LOAD;
                        state_next   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    lat_cnt_next = lat_cnt - 4'd1;
                end
            end
            RESP:    state_next = COOL;
            COOL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            lat_cnt             <= '0;
            blk_idx             <= '0;
            mem_ready           <= 1'b0;
            mem_block_read_data <= '0;
            rd_count            <= '0;
            wr_count            <= '0;
        end else begin
            state     <= state_next;
            lat_cnt   <= lat_cnt_next;
            blk_idx   <= blk_idx_next;
            mem_ready <= enter_resp;
            if (enter_resp) begin
                mem_block_read_data <= {mem[odd_idx], mem[blk_idx_next]};
                rd_count            <= rd_count + 16'd1;
            end
            if (mem_write_out) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // Array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_write_out) begin
            mem[word_idx] <= mem_write_data;
        end
    end

endmodule

// File: tb/tb_memoria_principal.sv
// Bench for memoria_principal: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_memoria_principal;
    localparam int unsigned D  = 256;
    localparam int unsigned L  = 4;
    localparam longint      LL = 4;

    logic         clk            = 1'b0;
    logic         reset          = 1'b0;
    logic [31:0]  mem_address    = '0;
    logic [63:0]  mem_write_data = '0;
    logic         mem_read_out   = 1'b0;
    logic         mem_write_out  = 1'b0;
    logic [127:0] mem_block_read_data;
    logic         mem_ready;
    logic         busy;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    int errors = 0;
    int checks = 0;

    memoria_principal #(.ADDR_WORDS(D), .READ_LATENCY(L)) dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_address         (mem_address),
        .mem_write_data      (mem_write_data),
        .mem_read_out        (mem_read_out),
        .mem_write_out       (mem_write_out),
        .mem_block_read_data (mem_block_read_data),
        .mem_ready           (mem_ready),
        .busy                (busy),
        .rd_count            (rd_count),
        .wr_count            (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a read accepted on edge n responds on edge n+L-1 and blocks
    // further acceptance until edge n+L+2.
    logic [63:0]  mdl [D];
    logic [127:0] m_data  = '0;
    logic         m_ready = 1'b0;
    logic         m_busy  = 1'b0;
    logic [15:0]  m_rd    = '0;
    logic [15:0]  m_wr    = '0;
    longint       ec      = 0;
    longint       resp_at = -1;
    longint       free_at = 0;
    int unsigned  blk     = 0;

    initial foreach (mdl[i]) mdl[i] = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data  = '0;
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_rd    = '0;
            m_wr    = '0;
            ec      = 0;
            resp_at = -1;
            free_at = 0;
        end else begin
            int unsigned widx;
            widx = (mem_address >> 3) % D;
            if (ec >= free_at && mem_read_out && !mem_write_out) begin
                blk     = widx - (widx % 2);
                resp_at = ec + LL - 1;
                free_at = ec + LL + 2;
            end
            m_ready = (ec == resp_at);
            if (m_ready) begin
                m_data = {mdl[blk + 1], mdl[blk]};
                m_rd   = m_rd + 16'd1;
            end
            if (mem_write_out) begin
                mdl[widx] = mem_write_data;
                m_wr      = m_wr + 16'd1;
            end
            m_busy = (ec + 1 < free_at);
            ec     = ec + 1;
        end
    end

    always @(negedge clk) begin
        check("cyc_ready", 128'(mem_ready), 128'(m_ready));
        check("cyc_busy", 128'(busy), 128'(m_busy));
        check("cyc_data", mem_block_read_data, m_data);
        check("cyc_rd_count", 128'(rd_count), 128'(m_rd));
        check("cyc_wr_count", 128'(wr_count), 128'(m_wr));
    end

    task automatic idle(input int n);
        mem_read_out  = 1'b0;
        mem_write_out = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] v);
        mem_write_out  = 1'b1;
        mem_address    = a;
        mem_write_data = v;
        @(negedge clk);
        mem_write_out  = 1'b0;
    endtask

    task automatic wait_ready(output logic [127:0] d, output int lat);
        bit found = 0;
        lat = 0;
        d   = '0;
        while (!found && lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_ready) begin
                found = 1;
                d     = mem_block_read_data;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no mem_ready within %0d cycles, required a pulse", lat);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [127:0] d, output int lat);
        mem_read_out = 1'b1;
        mem_address  = a;
        wait_ready(d, lat);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        int           lat;
        int           pulses, first, last, spacing_bad, width_bad;
        bit           prev;

        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", 128'(mem_ready), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_rd_count", 128'(rd_count), 128'd0);
        check("reset_wr_count", 128'(wr_count), 128'd0);
        check("reset_data", mem_block_read_data, 128'd0);
        #2 reset = 1'b0;
        @(negedge clk);

        do_read(32'h40, d, lat);
        check("zero_read_data", d, 128'd0);
        check("zero_read_lat", 128'(lat), 128'd4);

        apply_reset();
        do_write(32'h40, 64'h1111_2222_3333_4444);
        do_write(32'h48, 64'hAAAA_BBBB_CCCC_DDDD);
        idle(1);
        do_read(32'h44, d, lat);
        check("wr_rd_data", d, {64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444});
        check("wr_rd_lat", 128'(lat), 128'd4);
        check("wr_rd_wr_count", 128'(wr_count), 128'd2);
        check("wr_rd_rd_count", 128'(rd_count), 128'd1);

        mem_read_out = 1'b1;
        mem_address  = 32'h40;
        pulses = 0; first = -1; last = -1; spacing_bad = 0; width_bad = 0; prev = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                if (prev) width_bad++;
                if (last >= 0 && c - last != 6) spacing_bad++;
                if (pulses == 0) first = c;
                last = c;
                pulses++;
            end
            prev = mem_ready;
        end
        idle(10);
        check("held_pulses", 128'(pulses), 128'd3);
        check("held_first", 128'(first), 128'd4);
        check("held_spacing_bad", 128'(spacing_bad), 128'd0);
        check("held_width_bad", 128'(width_bad), 128'd0);

        // Read and write together: write wins, read is accepted one cycle later.
        mem_read_out   = 1'b1;
        mem_write_out  = 1'b1;
        mem_address    = 32'h50;
        mem_write_data = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        mem_write_out  = 1'b0;
        wait_ready(d, lat);
        idle(2);
        check("rw_data", d, {64'h0, 64'hDEAD_BEEF_0123_4567});
        check("rw_lat", 128'(lat), 128'd4);

        mem_read_out = 1'b1;
        mem_address  = 32'h80;
        @(negedge clk);
        @(negedge clk);
        mem_write_out  = 1'b1;
        mem_address    = 32'h88;
        mem_write_data = 64'h5;
        @(negedge clk);
        mem_write_out  = 1'b0;
        mem_address    = 32'h80;
        wait_ready(d, lat);
        idle(2);
        check("wait_wr_hi", 128'(d[127:64]), 128'h5);
        check("wait_wr_lo", 128'(d[63:0]), 128'h0);
        check("wait_wr_count", 128'(wr_count), 128'd4);

        apply_reset();
        mem_read_out = 1'b1;
        mem_address  = 32'h40;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_ready", 128'(mem_ready), 128'd0);
        check("midrst_rd_count", 128'(rd_count), 128'd0);
        mem_read_out = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        check("midrst_no_pulse", 128'(pulses), 128'd0);
        check("midrst_rd_after", 128'(rd_count), 128'd0);

        do_write(32'h800, 64'hCAFE_F00D_0000_0800);
        mem_write_out = 1'b1;
        mem_address   = 32'h100;
        for (int i = 0; i < 65535; i++) begin
            mem_write_data = 64'(i);
            @(negedge clk);
        end
        mem_write_out = 1'b0;
        check("wrap_wr_count", 128'(wr_count), 128'd0);
        do_read(32'h000, d, lat);
        check("wrap_addr_data", d, {64'h0, 64'hCAFE_F00D_0000_0800});

        do_write(32'h7F8, 64'h0FF0_0FF0_0000_00FF);
        do_write(32'hFF0, 64'h0FE0_0FE0_0000_00FE);
        idle(1);
        do_read(32'h7FC, d, lat);
        check("top_block_data", d, {64'h0FF0_0FF0_0000_00FF, 64'h0FE0_0FE0_0000_00FE});

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
